// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;
    localparam int NUM_PORTS      = 2;
    localparam int RAM_ADDR_WIDTH = 14;
    localparam int RAM_DATA_WIDTH = 32;

    typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_id_e;

    typedef struct packed {
        logic [RAM_ADDR_WIDTH-1:0]   addr;
        logic                        we;
        logic [RAM_DATA_WIDTH/8-1:0] be;
        logic [RAM_DATA_WIDTH-1:0]   wdata;
    } ram_req_t;
endpackage

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: 2-way round-robin grant core; prio flips only on contended grants.
module ram_arb_rr
    import ram_arb_pkg::*;
#(
    parameter int RESET_PRIO = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] gnt,
    output port_id_e             gnt_id
);
    logic prio;
    logic contended;

    assign contended = &req;

    always_comb begin
        gnt    = rst ? '0 : contended ? (prio ? 2'b10 : 2'b01) : req;
        gnt_id = gnt[1] ? PORT1 : PORT0;
    end

    // The winner of a contended cycle hands priority to the loser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prio <= RESET_PRIO[0];
        else if (contended)
            prio <= ~prio;
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between two OBI-style requesters.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int RESET_PRIO = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_PORTS-1:0]    p_req_i,
    output logic [NUM_PORTS-1:0]    p_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic                    p0_we_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic [NUM_PORTS-1:0]    p_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);
    logic     xfer;
    logic     sel1;
    logic     owner_valid;
    port_id_e gnt_id;
    port_id_e owner_id;

    ram_arb_rr #(.RESET_PRIO(RESET_PRIO)) u_rr (
        .clk    (clk_i),
        .rst    (rst_i),
        .req    (p_req_i),
        .gnt    (p_gnt_o),
        .gnt_id (gnt_id)
    );

    assign xfer = |(p_req_i & p_gnt_o);
    assign sel1 = gnt_id == PORT1;

    // Idle cycles drive zeros so nothing undefined reaches the RAM.
    always_comb begin
        ram_en_o    = xfer;
        ram_addr_o  = !xfer ? '0 : sel1 ? p1_addr_i  : p0_addr_i;
        ram_wdata_o = !xfer ? '0 : sel1 ? p1_wdata_i : p0_wdata_i;
        ram_we_o    = xfer && (sel1 ? p1_we_i : p0_we_i);
        ram_be_o    = !xfer ? '0 : sel1 ? p1_be_i    : p0_be_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_valid <= 1'b0;
            owner_id    <= PORT0;
        end else begin
            owner_valid <= xfer;
            owner_id    <= gnt_id;
        end
    end

    always_comb begin
        p_rvalid_o = {owner_valid && owner_id == PORT1, owner_valid && owner_id == PORT0};
        p0_rdata_o = p_rvalid_o[0] ? ram_rdata_i : '0;
        p1_rdata_o = p_rvalid_o[1] ? ram_rdata_i : '0;
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench with a RAM model and a transaction-level reference.
module tb_ram_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  p_req_i = '0;
    logic [1:0]  p_gnt_o;
    logic [13:0] p0_addr_i = '0, p1_addr_i = '0;
    logic        p0_we_i = 1'b0, p1_we_i = 1'b0;
    logic [3:0]  p0_be_i = '0, p1_be_i = '0;
    logic [31:0] p0_wdata_i = '0, p1_wdata_i = '0;
    logic [1:0]  p_rvalid_o;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic        ram_en_o, ram_we_o;
    logic [13:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_rdata_i = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic        port;
        logic        rd;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t q[$];

    logic [31:0] ram [0:31];
    logic [31:0] ref_mem [0:31];
    logic        turn;

    ram_port_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .RESET_PRIO(0)) dut (
        .clk_i(clk), .rst_i(rst_i), .p_req_i(p_req_i), .p_gnt_o(p_gnt_o),
        .p0_addr_i(p0_addr_i), .p1_addr_i(p1_addr_i), .p0_we_i(p0_we_i), .p1_we_i(p1_we_i),
        .p0_be_i(p0_be_i), .p1_be_i(p1_be_i), .p0_wdata_i(p0_wdata_i), .p1_wdata_i(p1_wdata_i),
        .p_rvalid_o(p_rvalid_o), .p0_rdata_o(p0_rdata_o), .p1_rdata_o(p1_rdata_o),
        .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM model: registered read, byte-masked write.
    always @(posedge clk) begin
        if (ram_en_o) begin
            ram_rdata_i <= ram[ram_addr_o[4:0]];
            if (ram_we_o)
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) ram[ram_addr_o[4:0]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: each cycle the rvalid vector must match the oldest due response.
    always @(negedge clk) begin
        exp_t        e;
        logic [1:0]  ev;
        logic [31:0] own_data;
        logic [31:0] other_data;
        ev = 2'b00;
        e = '{port: 1'b0, rd: 1'b0, data: 32'h0, due: 0};
        if (rst_i)
            q.delete();
        else if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            ev = e.port ? 2'b10 : 2'b01;
        end
        check("rvalid", {62'h0, p_rvalid_o}, {62'h0, ev});
        own_data   = e.port ? p1_rdata_o : p0_rdata_o;
        other_data = e.port ? p0_rdata_o : p1_rdata_o;
        if (ev != 2'b00 && e.rd) check("rdata", {32'h0, own_data}, {32'h0, e.data});
        if (ev == 2'b00) check("rdata_idle", {p0_rdata_o, p1_rdata_o}, 64'h0);
        else check("rdata_other_zero", {32'h0, other_data}, 64'h0);
    end

    task automatic step(input logic [1:0] req,
                        input logic [13:0] a0, input logic we0, input logic [3:0] be0, input logic [31:0] d0,
                        input logic [13:0] a1, input logic we1, input logic [3:0] be1, input logic [31:0] d1);
        logic [1:0]  eg;
        logic        p;
        logic [13:0] a;
        logic        we;
        logic [3:0]  be;
        logic [31:0] d;
        @(posedge clk);
        #1;
        p_req_i = req;
        p0_addr_i = a0; p0_we_i = we0; p0_be_i = be0; p0_wdata_i = d0;
        p1_addr_i = a1; p1_we_i = we1; p1_be_i = be1; p1_wdata_i = d1;
        eg = (req == 2'b11) ? (turn ? 2'b10 : 2'b01) : req;
        #1;
        check("gnt", {62'h0, p_gnt_o}, {62'h0, eg});
        if (eg == 2'b00) begin
            check("ram_idle", {12'h0, ram_en_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o}, 64'h0);
        end else begin
            p  = eg[1];
            a  = p ? a1 : a0;
            we = p ? we1 : we0;
            be = p ? be1 : be0;
            d  = p ? d1 : d0;
            check("ram_cmd", {48'h0, ram_en_o, ram_we_o, ram_addr_o}, {48'h0, 1'b1, we, a});
            if (we) check("ram_wr", {28'h0, ram_be_o, ram_wdata_o}, {28'h0, be, d});
            q.push_back('{port: p, rd: !we, data: ref_mem[a[4:0]], due: cyc + 1});
            if (we)
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[a[4:0]][8*b +: 8] = d[8*b +: 8];
            if (req == 2'b11) turn = ~p;
        end
    endtask

    task automatic rd(input logic [1:0] req, input logic [13:0] a0, input logic [13:0] a1);
        step(req, a0, 1'b0, 4'h0, 32'h0, a1, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        p_req_i = 2'b11;
        #1;
        check("gnt_in_reset", {62'h0, p_gnt_o}, 64'h0);
        check("ram_in_reset", {12'h0, ram_en_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o}, 64'h0);
        check("rvalid_in_reset", {62'h0, p_rvalid_o}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        p_req_i = 2'b00;
        turn = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram[i]     = 32'h0BAD_F00D + i * 32'h0101_0101;
            ref_mem[i] = 32'h0BAD_F00D + i * 32'h0101_0101;
        end
        turn = 1'b0;
        rst_i = 1'b1;
        p_req_i = 2'b11;
        repeat (2) @(posedge clk);
        #2;
        check("reset_gnt", {62'h0, p_gnt_o}, 64'h0);
        check("reset_outputs", {10'h0, p_rvalid_o, ram_en_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o}, 64'h0);
        check("reset_rdata", {p0_rdata_o, p1_rdata_o}, 64'h0);
        #1;
        rst_i = 1'b0;
        p_req_i = 2'b00;
        // P0 write then read back
        step(2'b01, 14'h010, 1'b1, 4'hF, 32'hDEADBEEF, 14'h0, 1'b0, 4'h0, 32'h0);
        rd(2'b01, 14'h010, 14'h0);
        rd(2'b00, 14'h0, 14'h0);
        // continuous contention
        for (int i = 0; i < 6; i++) rd(2'b11, 14'(i), 14'(i + 8));
        // solo P1 grants leave priority alone
        for (int i = 0; i < 3; i++) rd(2'b10, 14'h0, 14'(i + 3));
        rd(2'b11, 14'h7, 14'h9);
        // byte enables
        step(2'b10, 14'h0, 1'b0, 4'h0, 32'h0, 14'h005, 1'b1, 4'hF, 32'hFFFFFFFF);
        step(2'b10, 14'h0, 1'b0, 4'h0, 32'h0, 14'h005, 1'b1, 4'b0101, 32'h11223344);
        rd(2'b10, 14'h0, 14'h005);
        check("be_ref", {32'h0, ref_mem[5]}, 64'hFF22FF44);
        // back-to-back ownership switch
        rd(2'b01, 14'h011, 14'h0);
        rd(2'b10, 14'h0, 14'h012);
        rd(2'b00, 14'h0, 14'h0);
        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(2'($urandom_range(0, 3)),
                 14'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                 14'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
        // reset mid-read after priority has moved to P1
        rd(2'b11, 14'h1, 14'h2);
        rd(2'b01, 14'h3, 14'h0);
        reset_pulse();
        rd(2'b11, 14'h4, 14'h6);
        rd(2'b00, 14'h0, 14'h0);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter that shares the single-port on-chip RAM (`sp_ram`) between the CPU data interface and a secondary master, such as a flash-boot copy engine or a debug loader. Each requester sees an OBI-style request/grant/rvalid interface. The block drives the RAM's en/addr/wdata/we/be port and routes the 1-cycle-latency read data back to the requester that owns it. Arbitration is round-robin under contention, and back-to-back accesses run at full throughput.

## Interface
- `ADDR_WIDTH`, 14: RAM word-address width; matches `sp_ram` `ADDR_WIDTH`.
- `DATA_WIDTH`, 32: data width; byte-enable width is `DATA_WIDTH/8`.
- `RESET_PRIO`, 0: port that holds priority after reset (0 or 1).

- `clk_i`  in  1  single clock; RAM is on the same clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `p_req_i[1:0]`  in  2  per-port request.
- `p_gnt_o[1:0]`  out  2  per-port grant; combinational from `p_req_i` and the priority register.
- `p0_addr_i`, `p1_addr_i`  in  `ADDR_WIDTH`  word address.
- `p0_we_i`, `p1_we_i`  in  1  write enable.
- `p0_be_i`, `p1_be_i`  in  `DATA_WIDTH/8`  byte enables.
- `p0_wdata_i`, `p1_wdata_i`  in  `DATA_WIDTH`  write data.
- `p_rvalid_o[1:0]`  out  2  response valid; pulses one cycle after grant, for both reads and writes.
- `p0_rdata_o`, `p1_rdata_o`  out  `DATA_WIDTH`  read data; valid only while the port's `rvalid` is 1, otherwise 0.
- `ram_en_o`  out  1  RAM enable.
- `ram_addr_o`  out  `ADDR_WIDTH`  RAM address.
- `ram_wdata_o`  out  `DATA_WIDTH`  RAM write data.
- `ram_we_o`  out  1  RAM write enable.
- `ram_be_o`  out  `DATA_WIDTH/8`  RAM byte enables.
- `ram_rdata_i`  in  `DATA_WIDTH`  RAM read data; registered, valid the cycle after `en`.

## Operation
- **Grant rule**
  - If exactly one `p_req_i` bit is set, that port is granted.
  - If both are set, the port named by the `prio` register is granted.
  - At most one `gnt` bit is ever set.
  - A transfer happens in any cycle where `req & gnt` is set.
- **Priority register**
  - Updates only on a contended grant (both requesting): becomes the non-granted port.
  - Uncontended grants leave it unchanged.
  - Reset value is `RESET_PRIO`.
- **RAM drive**
  - `ram_en_o = |(p_req_i & p_gnt_o)`.
  - addr/we/be/wdata are muxed from the granted port.
  - When idle, `ram_en_o=0`, `ram_we_o=0`, `ram_be_o=0`, and addr/wdata are 0. No X propagates to the RAM.
- **Response tracking**
  - A registered `owner_valid`/`owner_id` pair records each transfer.
  - The next cycle, `p_rvalid_o[owner_id]=1` and that port's rdata = `ram_rdata_i`. The other port's rdata is 0.
  - Writes also produce `rvalid`, with rdata = `ram_rdata_i`; the requester must ignore it.
- **No backpressure on responses**: a requester must accept `rvalid` in the cycle it appears.
- **State per contended grant (two-state, `prio`)**
  - PRIO0 → PRIO1 when port 0 wins a contended cycle.
  - PRIO1 → PRIO0 when port 1 wins a contended cycle.

## Timing
- Grant latency is 0 cycles: `gnt` appears in the same cycle as `req` (combinational path).
- Response latency is 1 cycle: `rvalid` in cycle N+1 for a grant in cycle N.
- Throughput is one transfer per cycle, sustained, with no bubble when ownership switches between ports.
- Under continuous contention the grants alternate P0, P1, P0, … (or P1-first per `RESET_PRIO`). Worst-case wait is 1 cycle.
- **Simultaneous events**: a new grant in cycle N+1 coexists with the `rvalid` of cycle N's transfer. Both ports may see activity in the same cycle (one `gnt`, one `rvalid`).
- **Reset values**
  - `p_gnt_o=0`, `p_rvalid_o=0`, rdata=0, all `ram_*` = 0.
  - `prio=RESET_PRIO`, `owner_valid=0`.
  - `gnt` is forced to 0 while `rst_i` is high.
- **Reset mid-operation**: a pending response is dropped, so no `rvalid` is produced after reset deasserts. A write already presented to the RAM with `ram_en_o=1` on a clock edge before reset is committed.

## Structure
- **Package `ram_arb_pkg`**
  - `port_id_e` enum (`PORT0`, `PORT1`).
  - `ram_req_t` struct (addr, we, be, wdata), parameterised via localparams mirroring the SoC RAM width.
  - `NUM_PORTS=2` constant.
- **Sub-module `ram_arb_rr`**: 2-way round-robin core holding the `prio` register. Inputs: req, rst, clk. Outputs: one-hot gnt and `gnt_id`.
- **Top level**: the request mux and the response-routing register.

## Test plan
- **Single-port write then read**: P0 writes `0xDEADBEEF` to addr `0x010` with `be=4'hF`, then reads `0x010` → `gnt` in the same cycle, and `p0_rvalid` one cycle later with rdata `0xDEADBEEF`. `p1_rvalid` stays 0 throughout.
- **Continuous contention**: both ports read different addresses for 6 cycles with `RESET_PRIO=0` → grants P0, P1, P0, P1, P0, P1. Each `rvalid` returns the correct port's data one cycle after its grant.
- **Uncontended grants**: P1 alone for 3 cycles, then both request → P1 wins all three solo cycles, and P0 wins the first contended cycle (`prio` unchanged by solo grants).
- **Byte enables**: P1 writes `0x11223344` with `be=4'b0101` over `0xFFFFFFFF` → readback is `0xFF22FF44`.
- **Reset mid-read**: assert `rst_i` in the cycle after a P0 read grant → `p0_rvalid` is 0 during and after reset, all RAM outputs are 0, and the first contended grant after reset goes to `RESET_PRIO`.
- **Back-to-back ownership switch**: P0 read at addr A in cycle N, P1 read at addr B in cycle N+1 → `p0_rvalid` in N+1 with mem[A], then `p1_rvalid` in N+2 with mem[B]. No gap and no cross-routing.
